// File: rtl/lcd_pkg.sv
// Shared types and VGA 640x480 timing constants for the LCD scan-out block.
// LCD_SCANOUT_TESTPAT_EN adds the test-pattern field to the pipeline word.
package lcd_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef logic [1:0] shade_t;
  typedef shade_t [3:0] palette_t;

  localparam palette_t DEFAULT_PALETTE = 8'hE4;

  typedef enum logic {SWAP_IDLE, SWAP_PENDING} swap_state_t;

  // One timing slot travelling alongside the framebuffer read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic vb;
    logic act;
    logic win;
    logic fs;
`ifdef LCD_SCANOUT_TESTPAT_EN
    shade_t tp;
`endif
  } pipe_t;

  // Shade 0 is the brightest level, so the nibble is the inverted shade doubled.
  function automatic logic [3:0] chan_value(input logic en, input shade_t s);
    return en ? {~s, ~s} : 4'h0;
  endfunction

endpackage

// File: rtl/lcd_scanout_if.sv
// Framebuffer read port between the scan-out engine (master) and the pixel store (slave).
interface lcd_scanout_if #(parameter int AW = 16);
  // fb_rd qualifies fb_addr; there is no backpressure, and fb_data always returns
  // exactly RD_LAT clocks after the address it answers.
  logic [AW-1:0] fb_addr;
  logic          fb_rd;
  logic [1:0]    fb_data;

  modport master (output fb_addr, output fb_rd, input fb_data);
  modport slave  (input fb_addr, input fb_rd, output fb_data);
endinterface

// File: rtl/lcd_dda.sv
// One axis of the scaler: fractional accumulator plus a saturating source coordinate.
module lcd_dda #(
  parameter int NUM = 3,
  parameter int DEN = 10,
  parameter int MAX = 159,
  parameter int CW  = 8
) (
  input  logic          clk_4mhz,
  input  logic          rst,
  input  logic          clr,
  input  logic          step,
  output logic [CW-1:0] coord,
  output logic          inc
);

  localparam int AW = $clog2(DEN + NUM + 1);
  localparam logic [AW-1:0] NUM_C = AW'(NUM);
  localparam logic [AW-1:0] DEN_C = AW'(DEN);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_sum;
  logic          wrap;

  assign acc_sum = acc + NUM_C;
  assign wrap    = (acc_sum >= DEN_C);
  assign inc     = step && !clr && wrap && (coord != MAX_C);

  always_ff @(posedge clk_4mhz) begin
    if (rst || clr) begin
      acc   <= '0;
      coord <= '0;
    end else if (step) begin
      acc <= wrap ? (acc_sum - DEN_C) : acc_sum;
      if (inc) coord <= coord + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_scanout.sv
// VGA scan-out of a scaled, double-buffered 2-bit framebuffer through a 4-entry palette.
// Optional LCD_SCANOUT_TESTPAT_EN adds testpat_in, which swaps in a checkerboard.
module lcd_scanout
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter int SRC_W     = 160,
  parameter int SRC_H     = 144,
  parameter int SCALE_NUM = 3,
  parameter int SCALE_DEN = 10,
  parameter int H_START   = 54,
  parameter int V_START   = 0,
  parameter int RD_LAT    = 1
) (
  input  logic               clk_4mhz,
  input  logic               rst,
  lcd_scanout_if.master      fb,
  input  logic               pal_wr,
  input  logic [7:0]         pal_din,
  input  logic [2:0]         rgb_en,
  input  logic [1:0]         border_idx,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic [3:0]         vga_r,
  output logic [3:0]         vga_g,
  output logic [3:0]         vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               frame_start,
  output logic               vblank,
`ifdef LCD_SCANOUT_TESTPAT_EN
  input  logic               testpat_in,
`endif
  output swap_state_t        swap_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int LA = $clog2(SRC_W * SRC_H);
  localparam int XW = $clog2(SRC_W);
  localparam int YW = $clog2(SRC_H);
  localparam int WIN_W_RAW = SRC_W * SCALE_DEN / SCALE_NUM;
  localparam int WIN_H_RAW = SRC_H * SCALE_DEN / SCALE_NUM;
  localparam int WIN_W = (H_START + WIN_W_RAW > H_ACTIVE) ? H_ACTIVE - H_START : WIN_W_RAW;
  localparam int WIN_H = (V_START + WIN_H_RAW > V_ACTIVE) ? V_ACTIVE - V_START : WIN_H_RAW;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HWIN_BEG = HW'(H_START);
  localparam logic [HW-1:0] HWIN_END = HW'(H_START + WIN_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VWIN_BEG = VW'(V_START);
  localparam logic [VW-1:0] VWIN_END = VW'(V_START + WIN_H);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_last, v_last, in_h, in_v, in_win;
  logic [XW-1:0] x_src;
  logic [YW-1:0] y_src;
  logic          x_inc, y_inc;
  logic [LA-1:0] row_base;
  logic          buf_bit;
  palette_t      palette;
  pipe_t         cur, last;
  pipe_t         pipe [RD_LAT];
  shade_t        data_eff, pix_idx, shade;

  assign h_last = (h == H_LAST);
  assign v_last = (v == V_LAST);
  assign in_h   = (h >= HWIN_BEG) && (h < HWIN_END);
  assign in_v   = (v >= VWIN_BEG) && (v < VWIN_END);
  assign in_win = in_h && in_v;

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  lcd_dda #(.NUM(SCALE_NUM), .DEN(SCALE_DEN), .MAX(SRC_W - 1), .CW(XW)) u_dda_x (
    .clk_4mhz(clk_4mhz), .rst(rst), .clr(!in_h), .step(in_h),
    .coord(x_src), .inc(x_inc)
  );

  lcd_dda #(.NUM(SCALE_NUM), .DEN(SCALE_DEN), .MAX(SRC_H - 1), .CW(YW)) u_dda_y (
    .clk_4mhz(clk_4mhz), .rst(rst), .clr(!in_v), .step(in_v && h_last),
    .coord(y_src), .inc(y_inc)
  );

  // Row base tracks y*SRC_W incrementally so no multiplier is needed.
  always_ff @(posedge clk_4mhz) begin
    if (rst || !in_v) row_base <= '0;
    else if (y_inc)   row_base <= row_base + LA'(SRC_W);
  end

  assign fb.fb_addr = {buf_bit, row_base + LA'(x_src)};

  always_comb begin
    cur     = '0;
    cur.hs  = (h >= HS_BEG) && (h < HS_END);
    cur.vs  = (v >= VS_BEG) && (v < VS_END);
    cur.vb  = (v >= V_ACT_C);
    cur.act = (h < H_ACT_C) && (v < V_ACT_C);
    cur.win = in_win;
    cur.fs  = (h == '0) && (v == '0);
`ifdef LCD_SCANOUT_TESTPAT_EN
    cur.tp  = {2{x_src[3] ^ y_src[3]}};
`endif
  end

`ifdef LCD_SCANOUT_TESTPAT_EN
  assign fb.fb_rd = in_win && !rst && !testpat_in;
  assign data_eff = testpat_in ? last.tp : fb.fb_data;
`else
  assign fb.fb_rd = in_win && !rst;
  assign data_eff = fb.fb_data;
`endif

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last    = pipe[RD_LAT-1];
  assign pix_idx = last.win ? data_eff : border_idx;
  assign shade   = palette[pix_idx];

  always_ff @(posedge clk_4mhz) begin
    if (rst)         palette <= DEFAULT_PALETTE;
    else if (pal_wr) palette <= pal_din;
  end

  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      vga_r       <= last.act ? chan_value(rgb_en[2], shade) : 4'h0;
      vga_g       <= last.act ? chan_value(rgb_en[1], shade) : 4'h0;
      vga_b       <= last.act ? chan_value(rgb_en[0], shade) : 4'h0;
      vga_hs      <= !last.hs;
      vga_vs      <= !last.vs;
      frame_start <= last.fs;
      vblank      <= last.vb;
    end
  end

  // The flip lands on the same edge that raises frame_start, long before the window opens.
  always_ff @(posedge clk_4mhz) begin
    if (rst) begin
      swap_state <= SWAP_IDLE;
      buf_bit    <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (swap_state)
        SWAP_IDLE: if (swap_req) swap_state <= SWAP_PENDING;
        SWAP_PENDING: begin
          if (last.fs) begin
            swap_state <= SWAP_IDLE;
            buf_bit    <= !buf_bit;
            swap_ack   <= 1'b1;
          end
        end
        default: swap_state <= SWAP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Directed bench for lcd_scanout on a shrunken 56x37 raster with an 8x6 source image.
module tb_lcd_scanout;
  import lcd_pkg::*;

  localparam int HT = 56;
  localparam int VT = 37;
  localparam int FT = HT * VT;

  logic        clk_4mhz = 1'b0;
  logic        rst = 1'b1;
  logic        pal_wr = 1'b0;
  logic [7:0]  pal_din = 8'h00;
  logic [2:0]  rgb_en = 3'b111;
  logic [1:0]  border_idx = 2'd0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start, vblank;
  swap_state_t swap_state;
`ifdef LCD_SCANOUT_TESTPAT_EN
  logic        testpat_in = 1'b0;
`endif

  lcd_scanout_if #(.AW(7)) fb_bus ();

  lcd_scanout #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SRC_W(8), .SRC_H(6), .SCALE_NUM(3), .SCALE_DEN(10),
    .H_START(5), .V_START(14), .RD_LAT(1)
  ) dut (
    .clk_4mhz(clk_4mhz), .rst(rst), .fb(fb_bus.master),
    .pal_wr(pal_wr), .pal_din(pal_din), .rgb_en(rgb_en), .border_idx(border_idx),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .vblank(vblank),
`ifdef LCD_SCANOUT_TESTPAT_EN
    .testpat_in(testpat_in),
`endif
    .swap_state(swap_state)
  );

  // clock / reset
  always #5 clk_4mhz = ~clk_4mhz;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clk_4mhz);
    cyc++;
    if (swap_ack) ack_cnt++;
  endtask

  task automatic goto(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [2:0] en,
                                           input logic [1:0] bord, input logic [1:0] dat,
                                           input logic [7:0] pal);
    logic [1:0] idx;
    logic [1:0] s;
    logic [3:0] c;
    if (h >= 40 || v >= 30) return 12'h000;
    idx = (h >= 5 && h < 31 && v >= 14 && v < 30) ? dat : bord;
    s = pal[idx*2 +: 2];
    c = {~s, ~s};
    return {en[2] ? c : 4'h0, en[1] ? c : 4'h0, en[0] ? c : 4'h0};
  endfunction

  // Outputs lag the raster position by RD_LAT+1 = 2 clocks.
  task automatic scan_line(input string tag, input int line_cyc, input int v,
                           input logic [1:0] dat, input logic [7:0] pal);
    for (int hh = 0; hh < HT; hh++) exp_q.push_back(exp_rgb(hh, v, rgb_en, border_idx, dat, pal));
    for (int hh = 0; hh < HT; hh++) begin
      goto(line_cyc + 2 + hh);
      check(tag, {vga_r, vga_g, vga_b}, exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    check({tag, "_hs"}, vga_hs, 1'b1);
    check({tag, "_vs"}, vga_vs, 1'b1);
    check({tag, "_rd"}, fb_bus.fb_rd, 1'b0);
    check({tag, "_ack"}, swap_ack, 1'b0);
    check({tag, "_fs"}, frame_start, 1'b0);
    check({tag, "_vblank"}, vblank, 1'b0);
    check({tag, "_state"}, 32'(swap_state), 32'(SWAP_IDLE));
  endtask

  initial begin
    int low_cnt;
    int first_low;
    fb_bus.fb_data = 2'b01;

    // power-on reset, three clocks
    step(); step(); step();
    check_reset_outputs("por");
    rst = 1'b0;
    cyc = 0;

    // frame 0: timing, addresses, colour line
    goto(1); check("fs_pre", frame_start, 1'b0);
    goto(2); check("fs_first", frame_start, 1'b1);
    goto(3); check("fs_pulse", frame_start, 1'b0);

    low_cnt = 0;
    first_low = -1;
    for (int i = 0; i < HT; i++) begin
      goto(HT + 2 + i);
      if (!vga_hs) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("hs_width", low_cnt, 6);
    check("hs_start", first_low, 44);

    goto(13*HT + 5);  check("rd_above_win", fb_bus.fb_rd, 1'b0);
    goto(14*HT + 4);  check("rd_left_win", fb_bus.fb_rd, 1'b0);
    goto(14*HT + 5);  check("rd_win_first", fb_bus.fb_rd, 1'b1);
                      check("addr_win_first", fb_bus.fb_addr, 7'd0);
    goto(14*HT + 30); check("addr_right", fb_bus.fb_addr, 7'd7);
                      check("rd_right", fb_bus.fb_rd, 1'b1);
    goto(14*HT + 31); check("rd_past_right", fb_bus.fb_rd, 1'b0);

    scan_line("line15_rgb", 15*HT, 15, 2'b01, 8'hE4);

    goto(23*HT + 14); check("addr_v23", fb_bus.fb_addr, 7'd18);
    goto(24*HT + 15); check("addr_v24", fb_bus.fb_addr, 7'd27);
    goto(29*HT + 5);  check("rd_last_line", fb_bus.fb_rd, 1'b1);
    goto(29*HT + 30); check("addr_last", fb_bus.fb_addr, 7'd39);
    goto(29*HT + 57); check("vblank_pre", vblank, 1'b0);
    goto(30*HT + 2);  check("vblank_on", vblank, 1'b1);
    goto(30*HT + 5);  check("rd_clipped", fb_bus.fb_rd, 1'b0);
    goto(31*HT + 57); check("vs_pre", vga_vs, 1'b1);
    goto(32*HT + 2);  check("vs_on", vga_vs, 1'b0);
    goto(33*HT + 57); check("vs_last", vga_vs, 1'b0);
    goto(34*HT + 2);  check("vs_off", vga_vs, 1'b1);

    while (!frame_start && cyc < FT + 200) step();
    check("frame_len", cyc, FT + 2);

    // frame 1: double swap request, rgb enables, palette write
    goto(FT + 5); ack_cnt = 0;
    goto(FT + 10*HT + 3); swap_req = 1'b1; step(); swap_req = 1'b0;
    goto(FT + 12*HT + 7); swap_req = 1'b1; step(); swap_req = 1'b0;
    goto(FT + 12*HT + 9); check("swap_pending", 32'(swap_state), 32'(SWAP_PENDING));
                          check("ack_early", ack_cnt, 0);

    goto(FT + 13*HT); rgb_en = 3'b100; border_idx = 2'd3; fb_bus.fb_data = 2'b00;
    scan_line("line15_red", FT + 15*HT, 15, 2'b00, 8'hE4);

    goto(FT + 19*HT); rgb_en = 3'b111; border_idx = 2'd0; fb_bus.fb_data = 2'b01;
    goto(FT + 20*HT + 10); pal_wr = 1'b1; pal_din = 8'h1B;
    step(); pal_wr = 1'b0;
    check("pal_old", vga_g, 4'hA);
    step();
    check("pal_new", vga_g, 4'h5);
    goto(FT + 21*HT + 4); check("pal_border", vga_r, 4'h0);
    goto(FT + 25*HT); pal_wr = 1'b1; pal_din = 8'hE4;
    step(); pal_wr = 1'b0;

    // frame 2: single acknowledged flip
    goto(2*FT + 1); check("ack_before_fs", swap_ack, 1'b0);
    goto(2*FT + 2); check("ack_at_fs", swap_ack, 1'b1);
                    check("fs_with_ack", frame_start, 1'b1);
    goto(2*FT + 3); check("ack_pulse", swap_ack, 1'b0);
    goto(2*FT + 14*HT + 5); check("addr_buf1", fb_bus.fb_addr, 7'h40);
                            check("ack_count", ack_cnt, 1);
                            check("swap_idle", 32'(swap_state), 32'(SWAP_IDLE));

    // frame 3: request coincident with frame_start waits one frame
    goto(3*FT + 2); check("coinc_fs", frame_start, 1'b1);
                    check("coinc_no_ack", swap_ack, 1'b0);
    swap_req = 1'b1; step(); swap_req = 1'b0;
    goto(3*FT + 14*HT + 5); check("coinc_buf_hold", fb_bus.fb_addr, 7'h40);
    goto(4*FT + 2); check("coinc_ack", swap_ack, 1'b1);
    goto(4*FT + 14*HT + 5); check("coinc_buf0", fb_bus.fb_addr, 7'h00);

    // frame 4: reset mid-frame drops a pending swap
    goto(4*FT + 16*HT); swap_req = 1'b1; step(); swap_req = 1'b0;
    goto(4*FT + 18*HT); check("pend_before_rst", 32'(swap_state), 32'(SWAP_PENDING));
    goto(4*FT + 20*HT); rst = 1'b1; ack_cnt = 0;
    step();
    check_reset_outputs("mid_rst");
    step(); step();
    rst = 1'b0;
    cyc = 0;
    goto(1); check("rst_fs_pre", frame_start, 1'b0);
    goto(2); check("rst_fs", frame_start, 1'b1);
    goto(14*HT + 5); check("rst_addr", fb_bus.fb_addr, 7'h00);
                     check("rst_rd", fb_bus.fb_rd, 1'b1);
                     check("rst_no_ack", ack_cnt, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_scanout.md
LCD_SCANOUT -- requirements
Module: lcd_scanout

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch/sync widths in clocks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical equivalents in lines.
REQ-004 Parameters SRC_W/SRC_H, 160/144, framebuffer dimensions in pixels.
REQ-005 Parameters SCALE_NUM/SCALE_DEN, 3/10, source pixels advanced per output pixel (ratio, NUM<=DEN).
REQ-006 Parameters H_START/V_START, 54/0, first output pixel/line of image window.
REQ-007 Parameter RD_LAT, 1, framebuffer read latency in clocks (1..3).
REQ-008 clk_4mhz  in  1  pixel clock; all logic on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 fb_addr  out  clog2(SRC_W*SRC_H)+1  {buffer bit, linear address y*SRC_W+x}.
REQ-011 fb_rd  out  1  high when fb_addr is a valid in-window read.
REQ-012 fb_data  in  2  pixel index returned RD_LAT clocks after fb_addr.
REQ-013 pal_wr/pal_din  in  1/8  load palette register (4x2-bit shades, index0 in [1:0]).
REQ-014 rgb_en  in  3  per-channel enable {r,g,b}.
REQ-015 border_idx  in  2  palette index shown outside window.
REQ-016 swap_req  in  1  request to flip display buffer; swap_ack out 1, one-clock pulse.
REQ-017 vga_r/vga_g/vga_b  out  4 each; vga_hs/vga_vs out 1, active-low sync.
REQ-018 frame_start/vblank  out  1  pulse at line 0 pixel 0 / high during vertical blanking.

Function
REQ-019 Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1) SHALL wrap; v increments when h wraps.
REQ-020 hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
REQ-021 Window width WIN_W=floor(SRC_W*SCALE_DEN/SCALE_NUM), height WIN_H likewise, clipped to active area.
REQ-022 Source x/y SHALL advance by DDA: accumulator += SCALE_NUM per output pixel/line; on acc>=SCALE_DEN subtract SCALE_DEN, increment coordinate; no dividers or multipliers.
REQ-023 Linear address SHALL use running row base (+= SRC_W on source y step), reset to 0 at window top.
REQ-024 Source x SHALL saturate at SRC_W-1 and y at SRC_H-1; fb_rd low outside window.
REQ-025 Displayed pixel = palette[fb_data] in window, palette[border_idx] outside, 0 during blanking.
REQ-026 Channel value = {~shade,~shade} if its rgb_en bit set, else 0 (shade 0 = 4'hF).
REQ-027 Syncs, blank and colour SHALL share one pipeline of RD_LAT+1 clocks from fb_addr.
REQ-028 Buffer state machine IDLE->PENDING on swap_req; PENDING->IDLE at frame_start, toggling buffer bit and pulsing swap_ack same clock.
REQ-029 swap_req during PENDING SHALL be absorbed (single flip); swap_req coincident with frame_start flips at next frame_start.
REQ-030 pal_wr takes effect on next displayed pixel; palette write during active video permitted.

Reset
REQ-031 Reset: h=v=0, accumulators/address/buffer bit 0, state IDLE, palette 8'hE4, pipeline cleared.
REQ-032 During reset: colours 0, vga_hs=vga_vs=1, fb_rd=0, swap_ack=0, frame_start=0, vblank=0.
REQ-033 Reset mid-frame SHALL drop pending swap; first frame_start 1 clock after rst release plus pipeline.

Configuration
REQ-034 Macro LCD_SCANOUT_TESTPAT_EN: when defined, input testpat_in (1 bit) replaces fb_data with checkerboard index {x[3]^y[3], x[3]^y[3]} using source coordinates, fb_rd forced 0; when undefined, port and logic absent.

Structure
REQ-035 Package lcd_pkg SHALL hold shade_t (2-bit), palette_t, default palette constant, and VGA 640x480 timing constants.
REQ-036 Sub-module lcd_dda (one axis accumulator + saturating coordinate) SHALL be instantiated twice.

Verification
REQ-037 Defaults, after reset count clocks: frame = 800x525 clocks; hsync low 96 clocks starting h=656.
REQ-038 Window: fb_addr at (h=54,v=0)=0; at v=477 row base = 143*160; rightmost read address x=159.
REQ-039 fb_data constant 2'b01, palette E4 -> vga channels 4'hA, delayed exactly RD_LAT+1 from fb_rd.
REQ-040 swap_req pulsed twice mid-frame -> one swap_ack at next frame_start, fb_addr MSB=1 after.
REQ-041 rgb_en=3'b100, border_idx=3 -> outside window r=0,g=0,b=0; shade 0 in window r=F,g=b=0.
REQ-042 rst asserted at v=200 for 3 clocks -> outputs per REQ-032, frame_start at restart.
